xor_range_file: RTL
===================

// Module: xor_range_file
// PURPOSE
//  Parametrised multi-bit XOR register file: DEPTH entries of DATA_W bits each.
//  Supports point-XOR update, range-XOR query and bulk clear.
//  Queries are serviced by a multi-cycle scan engine that folds LANES entries per cycle.
//  Results return over a valid/ready response channel.
//  Sits beside the 1-bit range-XOR registers as their wide, deep, handshaked successor.
// PARAMETERS
//  DATA_W  8   width of each entry and of update/response data
//  DEPTH   16  number of entries, >=2 (need not be a power of two)
//  LANES   4   entries folded per scan cycle, 1..DEPTH
//  IDX_W   $clog2(DEPTH)  index width (derived, do not override)
// PORTS
//  clk        in   1       single clock, rising edge
//  reset      in   1       asynchronous, active-high reset
//  req_valid  in   1       request present
//  req_ready  out  1       request accepted when req_valid & req_ready at posedge
//  req_op     in   2       00 none, 01 QUERY, 10 UPDATE, 11 CLEAR
//  req_lo     in   IDX_W   QUERY range start; UPDATE target index
//  req_hi     in   IDX_W   QUERY range end (inclusive); ignored otherwise
//  req_val    in   DATA_W  UPDATE operand; ignored otherwise
//  rsp_valid  out  1       query result present
//  rsp_ready  in   1       result consumed when rsp_valid & rsp_ready at posedge
//  rsp_data   out  DATA_W  XOR of all entries in the queried range
//  rsp_err    out  1       query was illegal; rsp_data is 0 when set
// BEHAVIOUR
//  Reset (async): all entries 0, state IDLE, rsp_valid 0, rsp_data 0, rsp_err 0, req_ready 1.
//  FSM states:
//   IDLE: req_ready=1.
//   SCAN: req_ready=0.
//   DONE: req_ready=0, rsp_valid=1.
//  IDLE transitions on an accepted request:
//   op 00: no effect.
//   UPDATE: entry[lo] ^= req_val at the accepting edge; no response; stays IDLE.
//    lo>=DEPTH: update dropped.
//   CLEAR: all entries <= 0 at the accepting edge; no response; stays IDLE.
//   QUERY, legal range: acc<=0, ptr<=lo, remaining n<=range length; go to SCAN.
//   QUERY, illegal range: rsp_err<=1, rsp_data<=0; go directly to DONE.
//  SCAN, each cycle:
//   acc ^= entries ptr..ptr+k-1 with k=min(LANES,n); ptr advances k; n decreases by k.
//   When n reaches 0: rsp_data<=final acc, rsp_err<=0; go to DONE.
//  DONE: rsp_data/rsp_err held stable until rsp_valid & rsp_ready, then go to IDLE.
//  No request is accepted while SCAN/DONE, so entries are frozen during a query.
//   Results reflect the file at the accepting edge.
//  Latency: QUERY accepted at edge E -> rsp_valid high after edge E+ceil(n/LANES).
//   Illegal QUERY -> rsp_valid high after edge E+1.
//  Illegal range: lo>=DEPTH or hi>=DEPTH. lo>hi is also illegal unless RANGE_WRAP_EN.
//  lo==hi is legal: n=1, one scan cycle.
//  Reset during SCAN or DONE aborts the query; no response is produced.
//  XOR is bitwise over DATA_W; no carries, no width growth.
// CONFIGURATION
//  RANGE_WRAP_EN defined:
//   lo>hi is legal and wraps: lo..DEPTH-1 then 0..hi, n=DEPTH-lo+hi+1.
//   ptr wraps from DEPTH-1 to 0; one scan chunk may straddle the wrap.
//  RANGE_WRAP_EN undefined: lo>hi is an illegal range (rsp_err=1, rsp_data=0).
// TESTING
//  Reset, then QUERY lo=0 hi=15 -> rsp_data=0x00, rsp_err=0, rsp_valid 4 edges after accept.
//  UPDATE idx3 val=0xA5, then UPDATE idx3 val=0x0F, then QUERY lo=3 hi=3 -> 0xAA after 1 edge.
//  UPDATE idx0=0x01, idx5=0x10, idx15=0x80; QUERY 0..15 -> 0x91; QUERY 1..14 -> 0x10, latency 4.
//  QUERY lo=9 hi=2, wrap off -> rsp_err=1, data 0, 1 edge.
//   Wrap on, same entries as above: -> 0x81, latency ceil(10/4)=3.
//  Hold rsp_ready=0 for 5 cycles in DONE -> rsp_data stable, req_ready=0.
//   An UPDATE offered meanwhile is not applied.
//  Assert reset mid-SCAN -> rsp_valid stays 0, req_ready=1; then CLEAR and QUERY 0..15 -> 0x00.

Source files
------------

// File: rtl/xor_range_file.sv
// ---------------------------------------------------------------------------
// xor_range_file
//   Multi-bit XOR register file of DEPTH entries, DATA_W bits each.
//   Supports point-XOR update, bulk clear and range-XOR query. Queries are
//   serviced by a scan engine that folds up to LANES entries per cycle and
//   return their result over a valid/ready response channel.
//
// Parameters
//   DATA_W  width of each entry and of update/response data
//   DEPTH   number of entries (>= 2, any value)
//   LANES   entries folded per scan cycle (1..DEPTH)
//   IDX_W   index width, derived from DEPTH
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   req_valid  request present
//   req_ready  request accepted on req_valid & req_ready (high only in IDLE)
//   req_op     00 none, 01 QUERY, 10 UPDATE, 11 CLEAR
//   req_lo     QUERY range start / UPDATE target index
//   req_hi     QUERY range end (inclusive)
//   req_val    UPDATE operand
//   rsp_valid  query result present
//   rsp_ready  result consumed on rsp_valid & rsp_ready
//   rsp_data   XOR of all entries in the queried range (0 on error)
//   rsp_err    query range was illegal
//
// Build option
//   RANGE_WRAP_EN  when defined, lo > hi is a legal range that wraps from
//                  DEPTH-1 back to 0; otherwise lo > hi is rejected.
// ---------------------------------------------------------------------------
module xor_range_file #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  parameter  int LANES  = 4,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [IDX_W-1:0]  req_lo,
  input  logic [IDX_W-1:0]  req_hi,
  input  logic [DATA_W-1:0] req_val,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  // PW holds an index plus one carry bit (ptr + offset < 2*DEPTH).
  // NW holds a range length 0..DEPTH.
  localparam int PW = IDX_W + 1;
  localparam int NW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE   = 2'b00,
    OP_QUERY  = 2'b01,
    OP_UPDATE = 2'b10,
    OP_CLEAR  = 2'b11
  } op_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [NW-1:0]     n_q, n_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  op_e               req_op_e;
  logic              lo_ok;
  logic              hi_ok;
  logic              range_ok;
  logic [NW-1:0]     range_len;
  logic [NW-1:0]     k;
  logic [PW-1:0]     lane_idx;
  logic [PW-1:0]     ptr_sum;
  logic [DATA_W-1:0] fold;

  assign req_op_e = op_e'(req_op);

  // ---------------------------------------------------------------------
  // Range decode for an incoming QUERY
  // ---------------------------------------------------------------------
  assign lo_ok = ({1'b0, req_lo} < PW'(DEPTH));
  assign hi_ok = ({1'b0, req_hi} < PW'(DEPTH));

`ifdef RANGE_WRAP_EN
  always_comb begin
    range_ok = lo_ok && hi_ok;
    if (req_lo <= req_hi) begin
      range_len = NW'(req_hi) - NW'(req_lo) + NW'(1);
    end else begin
      // lo..DEPTH-1 followed by 0..hi
      range_len = NW'(DEPTH) - NW'(req_lo) + NW'(req_hi) + NW'(1);
    end
  end
`else
  always_comb begin
    range_ok  = lo_ok && hi_ok && (req_lo <= req_hi);
    range_len = NW'(req_hi) - NW'(req_lo) + NW'(1);
  end
`endif

  // ---------------------------------------------------------------------
  // Scan datapath: fold up to LANES entries starting at ptr_q. Lane
  // indices wrap modulo DEPTH so one chunk may straddle the end of the
  // file when wrapped ranges are enabled.
  // ---------------------------------------------------------------------
  assign k = (n_q < NW'(LANES)) ? n_q : NW'(LANES);

  always_comb begin
    fold     = '0;
    lane_idx = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_idx = {1'b0, ptr_q} + PW'(l);
      if (lane_idx >= PW'(DEPTH)) begin
        lane_idx = lane_idx - PW'(DEPTH);
      end
      if (NW'(l) < n_q) begin
        fold = fold ^ mem_q[lane_idx[IDX_W-1:0]];
      end
    end
  end

  always_comb begin
    ptr_sum = {1'b0, ptr_q} + PW'(k);
    if (ptr_sum >= PW'(DEPTH)) begin
      ptr_sum = ptr_sum - PW'(DEPTH);
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    ptr_d      = ptr_q;
    n_d        = n_q;
    err_d      = err_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    mem_d      = mem_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          case (req_op_e)
            OP_UPDATE: begin
              if (lo_ok) begin
                mem_d[req_lo] = mem_q[req_lo] ^ req_val;
              end
            end
            OP_CLEAR: begin
              for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
              end
            end
            OP_QUERY: begin
              // An illegal query runs one SCAN cycle with nothing to fold
              // and err_q set, so it answers one edge after acceptance
              // through the same completion path as a single-entry query.
              acc_d   = '0;
              state_d = ST_SCAN;
              if (range_ok) begin
                ptr_d = req_lo;
                n_d   = range_len;
                err_d = 1'b0;
              end else begin
                ptr_d = '0;
                n_d   = '0;
                err_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end

      ST_SCAN: begin
        acc_d = acc_q ^ fold;
        ptr_d = ptr_sum[IDX_W-1:0];
        n_d   = n_q - k;
        if (n_q == k) begin
          state_d    = ST_DONE;
          rsp_err_d  = err_q;
          rsp_data_d = err_q ? '0 : (acc_q ^ fold);
        end
      end

      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      ptr_q      <= '0;
      n_q        <= '0;
      err_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      ptr_q      <= ptr_d;
      n_q        <= n_d;
      err_q      <= err_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

endmodule
